serial_packet_ctrl: RTL

Parametrised successor to the serial packet controller. Deframes a bit-serial packet (start bit, destination port, byte count, payload, stop bit) into parallel words and delivers each word with a one-hot destination-channel strobe. Supports configurable port, length and data widths, a maximum packet length, and detection of framing and length errors. Sits between the serial link input and the per-port receive buffers.

---
 rtl/serial_packet_ctrl_if.sv | 29 ++
 rtl/serial_packet_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_ctrl_if.sv
// Bus interface for serial_packet_ctrl: the serial input plus the deframed word, strobe and status outputs.
// The slave modport is the controller's side; the master modport is the link/consumer side.
interface serial_packet_ctrl_if #(
    parameter int PORT_BITS = 2,
    parameter int LEN_BITS  = 4,
    parameter int DATA_BITS = 8
);
    localparam int NUM_PORTS = 2 ** PORT_BITS;

    logic                 serIn;
    logic [2:0]           state;
    logic [PORT_BITS-1:0] port_sel;
    logic [LEN_BITS-1:0]  bytes;
    logic [DATA_BITS-1:0] data_out;
    logic                 outValid;
    logic [NUM_PORTS-1:0] chan_valid;
    logic                 done;
    logic                 error;

    modport slave (
        input  serIn,
        output state, port_sel, bytes, data_out, outValid, chan_valid, done, error
    );

    modport master (
        output serIn,
        input  state, port_sel, bytes, data_out, outValid, chan_valid, done, error
    );
endinterface

// File: rtl/serial_packet_ctrl.sv
// Serial packet deframer: start, port, byte count, payload words, stop -> parallel words with one-hot channel strobe.
// Optional per-word even parity bit (state PAR) is enabled by defining PARITY_EN.
module serial_packet_ctrl #(
    parameter int PORT_BITS = 2,
    parameter int LEN_BITS  = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BYTES = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    serial_packet_ctrl_if.slave   bus
);
    localparam int NUM_PORTS = 2 ** PORT_BITS;
    localparam int SW0       = (PORT_BITS > LEN_BITS) ? PORT_BITS : LEN_BITS;
    localparam int SW        = (DATA_BITS > SW0) ? DATA_BITS : SW0;
    localparam int CW        = $clog2(SW) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PORT = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_STOP = 3'd4,
        S_ERR  = 3'd5,
        S_PAR  = 3'd6
    } state_t;

`ifdef PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [SW-1:0]        r_shift, w_shift_nxt, w_shift_in;
    logic [PORT_BITS-1:0] r_port_sel, w_port_nxt;
    logic [LEN_BITS-1:0]  r_bytes, w_bytes_nxt;
    logic [LEN_BITS-1:0]  r_byte_cnt, w_byte_cnt_nxt, w_byte_inc;
    logic [LEN_BITS-1:0]  w_len;
    logic [DATA_BITS-1:0] r_data_out, w_data_nxt;
    logic                 r_out_valid, w_valid_nxt;
    logic [NUM_PORTS-1:0] r_chan_valid;
    logic                 r_done, w_done_nxt;
    logic                 r_error;
    logic                 r_ones, w_ones_nxt;

    assign w_shift_in = {r_shift[SW-2:0], bus.serIn};
    assign w_len      = w_shift_in[LEN_BITS-1:0];
    assign w_byte_inc = r_byte_cnt + {{(LEN_BITS-1){1'b0}}, 1'b1};

    // Next-state and datapath decode; every field is shifted MSB-first through the shared shift register.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_port_nxt     = r_port_sel;
        w_bytes_nxt    = r_bytes;
        w_byte_cnt_nxt = r_byte_cnt;
        w_data_nxt     = r_data_out;
        w_valid_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        w_ones_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.serIn) begin
                    w_state_nxt   = S_PORT;
                    w_bit_cnt_nxt = {CW{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PORT: begin
                w_shift_nxt = w_shift_in;
                if (r_bit_cnt == CW'(PORT_BITS - 1)) begin
                    w_port_nxt    = w_shift_in[PORT_BITS-1:0];
                    w_bit_cnt_nxt = {CW{1'b0}};
                    w_state_nxt   = S_LEN;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                end
            end
            S_LEN: begin
                w_shift_nxt = w_shift_in;
                if (r_bit_cnt == CW'(LEN_BITS - 1)) begin
                    w_bit_cnt_nxt = {CW{1'b0}};
                    if ((w_len == {LEN_BITS{1'b0}}) || (w_len > LEN_BITS'(MAX_BYTES))) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_bytes_nxt    = w_len;
                        w_byte_cnt_nxt = {LEN_BITS{1'b0}};
                        w_state_nxt    = S_DATA;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                end
            end
            S_DATA: begin
                w_shift_nxt = w_shift_in;
                if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
                    w_bit_cnt_nxt = {CW{1'b0}};
`ifdef PARITY_EN
                    w_state_nxt = S_PAR;
`else
                    w_data_nxt     = w_shift_in[DATA_BITS-1:0];
                    w_valid_nxt    = 1'b1;
                    w_byte_cnt_nxt = w_byte_inc;
                    w_state_nxt    = (w_byte_inc == r_bytes) ? S_STOP : S_DATA;
`endif
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                if (even_parity(r_shift[DATA_BITS-1:0]) == bus.serIn) begin
                    w_data_nxt     = r_shift[DATA_BITS-1:0];
                    w_valid_nxt    = 1'b1;
                    w_byte_cnt_nxt = w_byte_inc;
                    w_state_nxt    = (w_byte_inc == r_bytes) ? S_STOP : S_DATA;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
`endif
            S_STOP: begin
                if (bus.serIn) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                // Leave only after two consecutive idle-high samples.
                if (bus.serIn && r_ones) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.serIn) begin
                    w_ones_nxt = 1'b1;
                end else begin
                    w_ones_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered output strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt    <= {CW{1'b0}};
            r_shift      <= {SW{1'b0}};
            r_port_sel   <= {PORT_BITS{1'b0}};
            r_bytes      <= {LEN_BITS{1'b0}};
            r_byte_cnt   <= {LEN_BITS{1'b0}};
            r_data_out   <= {DATA_BITS{1'b0}};
            r_out_valid  <= 1'b0;
            r_chan_valid <= {NUM_PORTS{1'b0}};
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_ones       <= 1'b0;
        end else begin
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_port_sel   <= w_port_nxt;
            r_bytes      <= w_bytes_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_data_out   <= w_data_nxt;
            r_out_valid  <= w_valid_nxt;
            r_chan_valid <= w_valid_nxt ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << r_port_sel)
                                        : {NUM_PORTS{1'b0}};
            r_done       <= w_done_nxt;
            r_error      <= (w_state_nxt == S_ERR);
            r_ones       <= w_ones_nxt;
        end
    end

    assign bus.state      = r_state;
    assign bus.port_sel   = r_port_sel;
    assign bus.bytes      = r_bytes;
    assign bus.data_out   = r_data_out;
    assign bus.outValid   = r_out_valid;
    assign bus.chan_valid = r_chan_valid;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
endmodule
